// File: rtl/jam_pkg.sv
// Shared types and elaboration helpers for the assignment-problem solver.
// The solver finds the cheapest worker/job assignment by brute force over all permutations.
package jam_pkg;

  localparam int DEFAULT_N  = 8;
  localparam int DEFAULT_CW = 7;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEARCH,
    DRAIN,
    DONE
  } state_t;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int w = 0; w < 31; w++)
      if ((1 << w) < value) width = w + 1;
    return width;
  endfunction

endpackage

// File: rtl/jam_nextperm.sv
// Combinational next lexicographic permutation of N indices.
// Index i of the permutation lives in bits [i*IW +: IW]; is_last flags the descending order.
module jam_nextperm
  import jam_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N*clog2(N)-1:0] perm,
  output logic [N*clog2(N)-1:0] next_perm,
  output logic                  is_last
);

  localparam int IW = clog2(N);

  logic [IW-1:0] a [N];
  logic [IW-1:0] s [N];
  logic [IW-1:0] a_k;
  logic [IW-1:0] a_l;
  logic [IW-1:0] r;
  int            k;
  int            l;

  // Pivot k: rightmost ascent. Swap it with the rightmost larger element l, then reverse the tail.
  // NOTE: every variable below gets a value before any branch reads it, so no latch is inferred;
  // blocking assignments are used because each step consumes the previous step's result.
  always_comb begin
    for (int i = 0; i < N; i++) a[i] = perm[i*IW +: IW];

    k = -1;
    for (int i = 0; i < N - 1; i++)
      if (a[i] < a[i+1]) k = i;

    a_k = '0;
    for (int i = 0; i < N; i++)
      if (i == k) a_k = a[i];

    l = -1;
    for (int i = 0; i < N; i++)
      if (k >= 0 && i > k && a[i] > a_k) l = i;

    a_l = '0;
    for (int i = 0; i < N; i++)
      if (i == l) a_l = a[i];

    for (int i = 0; i < N; i++) begin
      s[i] = a[i];
      if (i == k) s[i] = a_l;
      if (i == l) s[i] = a_k;
    end

    next_perm = '0;
    r         = '0;
    for (int i = 0; i < N; i++) begin
      r = s[i];
      for (int j = 0; j < N; j++)
        if (i > k && j == N + k - i) r = s[j];
      next_perm[i*IW +: IW] = r;
    end

    is_last = (k < 0);
  end

endmodule

// File: rtl/jam_solver.sv
// Brute-force assignment solver: loads an N x N cost matrix through a W/J read port,
// then scores every permutation in lexicographic order through a two-stage pipeline.
module jam_solver
  import jam_pkg::*;
#(
  parameter  int N  = DEFAULT_N,
  parameter  int CW = DEFAULT_CW,
  localparam int IW = clog2(N),
  localparam int SW = CW + 3
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  output logic            busy,
  output logic [IW-1:0]   W,
  output logic [IW-1:0]   J,
  input  logic [CW-1:0]   Cost,
  output logic            Valid,
  output logic [SW-1:0]   MinCost,
  output logic [15:0]     MatchCount,
  output logic [N*IW-1:0] BestSeq
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  function automatic logic [N*IW-1:0] identity_perm();
    logic [N*IW-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[i*IW +: IW] = IW'(i);
    return p;
  endfunction

  localparam logic [N*IW-1:0] IDENTITY = identity_perm();

  state_t          state;
  logic [CW-1:0]   matrix [N][N];
  logic            load_done;
  logic            cap_en;
  logic [IW-1:0]   cap_w;
  logic [IW-1:0]   cap_j;
  logic [N*IW-1:0] perm;
  logic [N*IW-1:0] next_perm;
  logic            is_last;
  logic [SW-1:0]   perm_sum;
  logic [SW-1:0]   s1_sum;
  logic [N*IW-1:0] s1_perm;
  logic            s1_en;
  logic [SW-1:0]   min_sum;
  logic            drain_cnt;

  jam_nextperm #(.N(N)) u_nextperm (
    .perm      (perm),
    .next_perm (next_perm),
    .is_last   (is_last)
  );

  always_comb begin
    perm_sum = '0;
    for (int i = 0; i < N; i++)
      perm_sum = perm_sum + SW'(matrix[i][perm[i*IW +: IW]]);
  end

  // NOTE: the cost matrix is plain storage fully rewritten by every LOAD, so it has no reset.
  always_ff @(posedge CLK) begin
    if (cap_en) matrix[cap_w][cap_j] <= Cost;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      busy       <= 1'b0;
      Valid      <= 1'b0;
      W          <= '0;
      J          <= '0;
      load_done  <= 1'b0;
      cap_en     <= 1'b0;
      cap_w      <= '0;
      cap_j      <= '0;
      perm       <= '0;
      s1_en      <= 1'b0;
      s1_sum     <= '0;
      s1_perm    <= '0;
      min_sum    <= '1;
      drain_cnt  <= 1'b0;
      MinCost    <= '0;
      MatchCount <= '0;
      BestSeq    <= '0;
    end else begin
      Valid <= 1'b0;

      // Cost arrives one cycle after its address, so the write address trails W/J by one cycle.
      cap_en <= (state == LOAD) && !load_done;
      cap_w  <= W;
      cap_j  <= J;

      s1_en   <= (state == SEARCH);
      s1_sum  <= perm_sum;
      s1_perm <= perm;

      if (s1_en) begin
        if (s1_sum < min_sum) begin
          min_sum    <= s1_sum;
          MatchCount <= 16'd1;
          BestSeq    <= s1_perm;
        end else if (s1_sum == min_sum && MatchCount != 16'hFFFF) begin
          MatchCount <= MatchCount + 16'd1;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            busy       <= 1'b1;
            W          <= '0;
            J          <= '0;
            load_done  <= 1'b0;
            min_sum    <= '1;
            MatchCount <= '0;
            BestSeq    <= '0;
          end
        end
        LOAD: begin
          if (load_done) begin
            state <= SEARCH;
            perm  <= IDENTITY;
          end else if (J == LAST_IDX) begin
            J <= '0;
            if (W == LAST_IDX) begin
              W         <= '0;
              load_done <= 1'b1;
            end else begin
              W <= W + IW'(1);
            end
          end else begin
            J <= J + IW'(1);
          end
        end
        SEARCH: begin
          if (is_last) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end else begin
            perm <= next_perm;
          end
        end
        DRAIN: begin
          if (drain_cnt) state <= DONE;
          else           drain_cnt <= 1'b1;
        end
        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          Valid   <= 1'b1;
          MinCost <= min_sum;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/jam_solver.md
JAM_SOLVER -- requirements
Module: jam_solver

Interface
REQ-001 Parameter N, default 8: worker/job count, legal range 2..8.
REQ-002 Parameter CW, default 7: width of one cost entry.
REQ-003 Derived IW = clog2(N): index width. SW = CW+3: sum width.
REQ-004 CLK  in  1  clock; all state changes on its rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  starts a run; sampled only in IDLE.
REQ-007 busy  out  1  high from the edge that accepts start until the edge that ends DONE.
REQ-008 W  out  IW  worker index of the cost read.
REQ-009 J  out  IW  job index of the cost read.
REQ-010 Cost  in  CW  cost of (W,J) driven in the previous cycle.
REQ-011 Valid  out  1  one-cycle pulse; result is final.
REQ-012 MinCost  out  SW  minimum total assignment cost.
REQ-013 MatchCount  out  16  number of permutations that reach MinCost.
REQ-014 BestSeq  out  N*IW  lexicographically first minimum permutation; job of worker i in bits [i*IW +: IW].

Function
REQ-015 FSM states: IDLE, LOAD, SEARCH, DRAIN, DONE.
REQ-016 IDLE: when start=1, go to LOAD; clear min to all-ones, MatchCount to 0 and BestSeq to 0.
REQ-017 LOAD: drive W/J row-major (0,0),(0,1)..(N-1,N-1), one pair per cycle, N*N cycles.
REQ-018 LOAD: capture each Cost one cycle later into an internal N x N matrix.
REQ-019 LOAD: one extra capture cycle after the last address, then go to SEARCH.
REQ-020 W and J are 0 in every state except LOAD.
REQ-021 SEARCH: permutation register starts at identity (0,1,..,N-1) and advances to the next lexicographic permutation every cycle.
REQ-022 SEARCH: exactly N! permutations issued, one per cycle, no gaps.
REQ-023 SEARCH: after the descending permutation is issued, go to DRAIN.
REQ-024 Pipeline stage 1: register sum of matrix[i][perm[i]] over all i (SW bits, no overflow possible).
REQ-025 Pipeline stage 2, compare against min:
  - sum < min: min=sum, count=1, BestSeq=perm.
  - sum == min: count+1, min and BestSeq unchanged.
  - sum > min: no change.
REQ-026 DRAIN: lasts 2 cycles so the last permutation is compared; then go to DONE.
REQ-027 DONE: Valid=1 for one cycle, then go to IDLE.
REQ-028 Valid rises exactly N*N+N!+4 cycles after the edge that sampled start.
REQ-029 MinCost, MatchCount and BestSeq hold the last result after Valid until the next accepted start.
REQ-030 start while busy is ignored; a start held high re-triggers only from IDLE.
REQ-031 MatchCount does not wrap: it saturates at 65535 (max reachable value is 40320).

Reset
REQ-032 RST asserted at any time: state=IDLE; busy, Valid, W, J, MinCost, MatchCount, BestSeq = 0; min = all-ones.
REQ-033 RST in mid-run aborts the run; no Valid follows; the next start begins a clean run.

Structure
REQ-034 Package jam_pkg holds: state enum, clog2 function, defaults N=8 and CW=7.
REQ-035 Sub-module jam_nextperm: combinational next lexicographic permutation of N indices, plus an is_last flag (input descending); instantiated once.

Verification
REQ-036 N=8, all Cost=5 -> MinCost 40, MatchCount 40320, BestSeq identity, Valid at cycle 40388.
REQ-037 N=8, Cost 0 on diagonal and 10 elsewhere -> MinCost 0, MatchCount 1, BestSeq identity.
REQ-038 N=8, Cost 1 where J=7-W and 50 elsewhere -> MinCost 8, MatchCount 1, BestSeq (7,6,..,0); checks that the final permutation is evaluated.
REQ-039 N=3, Cost[i][j]=(i+1)(j+1) -> MinCost 10, MatchCount 1, BestSeq (2,1,0), Valid 19 cycles after start.
REQ-040 RST pulsed mid-SEARCH -> all outputs 0, no Valid; then start -> result matches REQ-037; start pulses while busy are ignored.
